// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit:
//   - FSM state encoding (plain 3-bit constants, legacy-compatible)
//   - opcode class enum produced by the opcode decoder
//   - opcode table values (8-bit, zero-extended to OPCODE_W by users)
//   - ALU operation codes
// -----------------------------------------------------------------------------
package ctrl_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_FAULT  = 3'd6;

    // What the sequencer needs to know about an opcode
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,   // ALU ops and moves: EXEC then WB
        CLS_LD      = 3'd1,   // EXEC (address), MEM read, WB
        CLS_ST      = 3'd2,   // EXEC (address), MEM write
        CLS_JMP     = 3'd3,   // EXEC only, redirects PC
        CLS_HALT    = 3'd4,   // terminal
        CLS_ILLEGAL = 3'd5    // unknown, retired as a NOP after DECODE
    } op_class_t;

    // Opcode table
    localparam logic [7:0] OP_MOVI = 8'h00;
    localparam logic [7:0] OP_MOVR = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_JMP  = 8'h05;
    localparam logic [7:0] OP_ADD  = 8'h09;
    localparam logic [7:0] OP_SUB  = 8'h0A;
    localparam logic [7:0] OP_AND  = 8'h0B;
    localparam logic [7:0] OP_OR   = 8'h0C;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // ALU operation codes
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;   // also used as pass-through
    localparam logic [1:0] ALU_SUB = 2'b11;

    // States in which the unit waits on mem_ready
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM);
    endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// -----------------------------------------------------------------------------
// ctrl_opcode_decode
// Purely combinational classification of an opcode.
// Ports:
//   i_opcode      opcode to classify (the latched IR opcode in the top)
//   o_class       sequencing class (ALU/LD/ST/JMP/HALT/ILLEGAL)
//   o_alu_op      ALU operation used in EXEC (and held through MEM/WB)
//   o_alu_src     ALU B operand select: 1 = immediate, 0 = register
//   o_reg_to_reg  WB source select: 1 for moves, 0 otherwise
//   o_legal       opcode is in the table
// -----------------------------------------------------------------------------
module ctrl_opcode_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 2
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output op_class_t           o_class,
    output logic [ALUOP_W-1:0]  o_alu_op,
    output logic                o_alu_src,
    output logic                o_reg_to_reg,
    output logic                o_legal
);

    always_comb begin
        o_class      = CLS_ILLEGAL;
        o_alu_op     = '0;
        o_alu_src    = 1'b0;
        o_reg_to_reg = 1'b0;
        o_legal      = 1'b1;
        case (i_opcode)
            OPCODE_W'(OP_MOVI): begin
                o_class      = CLS_ALU;
                o_alu_op     = ALUOP_W'(ALU_ADD);
                o_alu_src    = 1'b1;
                o_reg_to_reg = 1'b1;
            end
            OPCODE_W'(OP_MOVR): begin
                o_class      = CLS_ALU;
                o_alu_op     = ALUOP_W'(ALU_ADD);
                o_reg_to_reg = 1'b1;
            end
            OPCODE_W'(OP_ADD): begin
                o_class  = CLS_ALU;
                o_alu_op = ALUOP_W'(ALU_ADD);
            end
            OPCODE_W'(OP_SUB): begin
                o_class  = CLS_ALU;
                o_alu_op = ALUOP_W'(ALU_SUB);
            end
            OPCODE_W'(OP_AND): begin
                o_class  = CLS_ALU;
                o_alu_op = ALUOP_W'(ALU_AND);
            end
            OPCODE_W'(OP_OR): begin
                o_class  = CLS_ALU;
                o_alu_op = ALUOP_W'(ALU_OR);
            end
            OPCODE_W'(OP_LD): begin
                o_class  = CLS_LD;
                o_alu_op = ALUOP_W'(ALU_ADD);   // base + offset
            end
            OPCODE_W'(OP_ST): begin
                o_class  = CLS_ST;
                o_alu_op = ALUOP_W'(ALU_AND);
            end
            OPCODE_W'(OP_JMP): begin
                o_class   = CLS_JMP;
                o_alu_op  = ALUOP_W'(ALU_ADD);
                o_alu_src = 1'b1;               // pass the immediate target
            end
            OPCODE_W'(OP_HALT): begin
                o_class = CLS_HALT;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on a
// memory-ready handshake in FETCH and MEM, and drives the datapath controls.
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_opcode          opcode field of the fetched word, sampled on o_ir_load
//   i_mem_ready       memory completes the current read/write this cycle
//   o_ir_load         load IR / latch opcode (FETCH and mem_ready)
//   o_pc_write        update PC (PC+1 in FETCH, jump target in EXEC)
//   o_jump            PC source = jump target
//   o_mem_read        memory read (instruction in FETCH, data in MEM)
//   o_i_or_d          0 = instruction address, 1 = data address
//   o_mem_write       data memory write
//   o_alu_op          ALU operation
//   o_alu_src         ALU B operand: 1 = immediate, 0 = register
//   o_reg_write       register-file write enable (WB)
//   o_reg_to_reg      WB source: 1 = move result, 0 = memory/ALU path
//   o_busy            high except in HALT and FAULT
//   o_halted          sticky, HALT executed
//   o_illegal_op      one-cycle pulse in DECODE for an unknown opcode
//   o_fault           sticky, memory timeout
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 2,
    parameter int TIMEOUT  = 15     // 1..255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    output logic                o_ir_load,
    output logic                o_pc_write,
    output logic                o_jump,
    output logic                o_mem_read,
    output logic                o_i_or_d,
    output logic                o_mem_write,
    output logic [ALUOP_W-1:0]  o_alu_op,
    output logic                o_alu_src,
    output logic                o_reg_write,
    output logic                o_reg_to_reg,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_illegal_op,
    output logic                o_fault
);

    localparam int CNT_W = 8;

    state_t              r_state;
    state_t              w_next_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]    w_wait_cnt_next;
    logic                w_timeout;
    logic                w_ir_load;

    op_class_t           w_class;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_alu_src;
    logic                w_reg_to_reg;
    logic                w_legal;

    // Decoding is done on the latched opcode so the opcode input only matters
    // in the cycle it is loaded.
    ctrl_opcode_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_dec (
        .i_opcode     (r_opcode),
        .o_class      (w_class),
        .o_alu_op     (w_alu_op),
        .o_alu_src    (w_alu_src),
        .o_reg_to_reg (w_reg_to_reg),
        .o_legal      (w_legal)
    );

    assign w_ir_load = (r_state == ST_FETCH) && i_mem_ready;
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT));

    // The counter only runs while waiting in FETCH/MEM; every other state and
    // every mem_ready return it to zero, which also covers clearing on entry.
    always_comb begin
        w_wait_cnt_next = '0;
        if (is_wait_state(r_state) && !i_mem_ready && !w_timeout)
            w_wait_cnt_next = r_wait_cnt + 1'b1;
    end

    // Next-state logic. In FETCH/MEM a mem_ready that arrives together with
    // the timeout takes priority over the fault.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (i_mem_ready)    w_next_state = ST_DECODE;
                else if (w_timeout) w_next_state = ST_FAULT;
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_HALT:    w_next_state = ST_HALT;
                    CLS_ILLEGAL: w_next_state = ST_FETCH;
                    default:     w_next_state = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (w_class)
                    CLS_JMP:        w_next_state = ST_FETCH;
                    CLS_LD, CLS_ST: w_next_state = ST_MEM;
                    default:        w_next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (i_mem_ready)
                    w_next_state = (w_class == CLS_LD) ? ST_WB : ST_FETCH;
                else if (w_timeout)
                    w_next_state = ST_FAULT;
            end
            ST_WB:    w_next_state = ST_FETCH;
            ST_HALT:  w_next_state = ST_HALT;
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_FETCH;
            r_opcode   <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_ir_load)
                r_opcode <= i_opcode;
        end
    end

    // Output decode. While rst is asserted everything except busy is forced
    // low so an in-flight memory request is withdrawn immediately.
    always_comb begin
        o_ir_load    = 1'b0;
        o_pc_write   = 1'b0;
        o_jump       = 1'b0;
        o_mem_read   = 1'b0;
        o_i_or_d     = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_op     = '0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_to_reg = 1'b0;
        o_busy       = 1'b0;
        o_halted     = 1'b0;
        o_illegal_op = 1'b0;
        o_fault      = 1'b0;
        if (i_rst) begin
            o_busy = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    o_busy     = 1'b1;
                    o_mem_read = 1'b1;
                    o_ir_load  = w_ir_load;
                    o_pc_write = w_ir_load;
                end
                ST_DECODE: begin
                    o_busy       = 1'b1;
                    o_illegal_op = ~w_legal;
                end
                ST_EXEC: begin
                    o_busy     = 1'b1;
                    o_alu_op   = w_alu_op;
                    o_alu_src  = w_alu_src;
                    o_jump     = (w_class == CLS_JMP);
                    o_pc_write = (w_class == CLS_JMP);
                end
                ST_MEM: begin
                    o_busy      = 1'b1;
                    o_i_or_d    = 1'b1;
                    o_mem_read  = (w_class == CLS_LD);
                    o_mem_write = (w_class == CLS_ST);
                    o_alu_op    = w_alu_op;
                    o_alu_src   = w_alu_src;
                end
                ST_WB: begin
                    o_busy       = 1'b1;
                    o_reg_write  = 1'b1;
                    o_reg_to_reg = w_reg_to_reg;
                    o_alu_op     = w_alu_op;
                    o_alu_src    = w_alu_src;
                end
                ST_HALT:  o_halted = 1'b1;
                ST_FAULT: o_fault  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Table of per-opcode expectations, hand-written multi-cycle sequences, and a
// randomized run against a phase-queue reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       ir_load, pc_write, jump, mem_read, i_or_d, mem_write;
    logic [1:0] alu_op;
    logic       alu_src, reg_write, reg_to_reg, busy, halted, illegal_op, fault;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(8), .ALUOP_W(2), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_ir_load(ir_load), .o_pc_write(pc_write), .o_jump(jump),
        .o_mem_read(mem_read), .o_i_or_d(i_or_d), .o_mem_write(mem_write),
        .o_alu_op(alu_op), .o_alu_src(alu_src), .o_reg_write(reg_write),
        .o_reg_to_reg(reg_to_reg), .o_busy(busy), .o_halted(halted),
        .o_illegal_op(illegal_op), .o_fault(fault)
    );

    typedef struct packed {
        logic       ir_load, pc_write, jump, mem_read, i_or_d, mem_write;
        logic [1:0] alu_op;
        logic       alu_src, reg_write, reg_to_reg, busy, halted, illegal_op, fault;
    } outv_t;

    outv_t w_out;
    assign w_out = {ir_load, pc_write, jump, mem_read, i_or_d, mem_write, alu_op,
                    alu_src, reg_write, reg_to_reg, busy, halted, illegal_op, fault};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic r, input logic rdy, input logic [7:0] op);
        @(negedge clk);
        rst = r; mem_ready = rdy; opcode = op;
        #1;
    endtask

    function automatic outv_t reset_exp();
        outv_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00);
        chk("reset_outputs", 32'(w_out), 32'(reset_exp()));
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        byte        kind;   // A=alu/mov L=ld S=st J=jmp H=halt I=illegal
        logic [1:0] alu;
        logic       src;
        logic       r2r;
    } opi_t;

    function automatic opi_t op_info(input logic [7:0] op);
        case (op)
            8'h00: return '{"A", 2'b10, 1'b1, 1'b1};
            8'h01: return '{"A", 2'b10, 1'b0, 1'b1};
            8'h09: return '{"A", 2'b10, 1'b0, 1'b0};
            8'h0A: return '{"A", 2'b11, 1'b0, 1'b0};
            8'h0B: return '{"A", 2'b00, 1'b0, 1'b0};
            8'h0C: return '{"A", 2'b01, 1'b0, 1'b0};
            8'h02: return '{"L", 2'b10, 1'b0, 1'b0};
            8'h03: return '{"S", 2'b00, 1'b0, 1'b0};
            8'h05: return '{"J", 2'b10, 1'b1, 1'b0};
            8'hFF: return '{"H", 2'b00, 1'b0, 1'b0};
            default: return '{"I", 2'b00, 1'b0, 1'b0};
        endcase
    endfunction

    byte        m_q[$];     // remaining phases of the current instruction
    bit         m_term;
    byte        m_tph;
    int         m_wait;
    logic [7:0] m_op;

    task automatic m_reset();
        m_q.delete(); m_term = 0; m_tph = "F"; m_wait = 0; m_op = 8'h00;
    endtask

    function automatic byte m_phase();
        if (m_term) return m_tph;
        if (m_q.size() == 0) return "F";
        return m_q[0];
    endfunction

    function automatic outv_t model_exp(input byte ph, input logic [7:0] lop, input logic rdy);
        outv_t e = '0;
        opi_t  i = op_info(lop);
        case (ph)
            "F": begin e.busy = 1; e.mem_read = 1; e.ir_load = rdy; e.pc_write = rdy; end
            "D": begin e.busy = 1; e.illegal_op = (i.kind == "I"); end
            "E": begin
                e.busy = 1; e.alu_op = i.alu; e.alu_src = i.src;
                e.jump = (i.kind == "J"); e.pc_write = (i.kind == "J");
            end
            "M": begin
                e.busy = 1; e.i_or_d = 1; e.alu_op = i.alu; e.alu_src = i.src;
                e.mem_read = (i.kind == "L"); e.mem_write = (i.kind == "S");
            end
            "W": begin
                e.busy = 1; e.reg_write = 1; e.reg_to_reg = i.r2r;
                e.alu_op = i.alu; e.alu_src = i.src;
            end
            "H": e.halted = 1;
            "X": e.fault = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic m_step(input logic rdy, input logic [7:0] op);
        byte ph;
        opi_t i;
        if (!m_term) begin
            ph = m_phase();
            if (ph == "F" || ph == "M") begin
                if (rdy) begin
                    if (ph == "F") begin
                        m_op = op;
                        i = op_info(op);
                        m_q.push_back("D");
                        case (i.kind)
                            "A": begin m_q.push_back("E"); m_q.push_back("W"); end
                            "L": begin m_q.push_back("E"); m_q.push_back("M"); m_q.push_back("W"); end
                            "S": begin m_q.push_back("E"); m_q.push_back("M"); end
                            "J": m_q.push_back("E");
                            "H": m_q.push_back("H");
                            default: ;
                        endcase
                    end else begin
                        void'(m_q.pop_front());
                    end
                    m_wait = 0;
                end else if (m_wait == TIMEOUT) begin
                    m_term = 1; m_tph = "X";
                end else begin
                    m_wait++;
                end
            end else begin
                void'(m_q.pop_front());
                m_wait = 0;
            end
            if (m_q.size() > 0 && m_q[0] == "H") begin
                m_term = 1; m_tph = "H"; m_q.delete();
            end
        end
    endtask

    function automatic logic [7:0] pick_op();
        logic [7:0] ops[9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        int r = $urandom_range(0, 99);
        if (r < 2)  return 8'hFF;
        if (r < 85) return ops[$urandom_range(0, 8)];
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] op;
        int         lat;      // cycles from ir_load to the next ir_load
        logic [1:0] ex_alu;   // alu_op sampled at cycle 2
        logic       ex_src;
        logic       r2r;      // reg_to_reg while reg_write
        logic       rw, mw, jp, il;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int         lat, cnt_m;
        logic [1:0] s_alu;
        logic       s_src, s_r2r, s_rw, s_mw, s_jp, s_il, rr;
        int         prob;
        outv_t      e;

        tbl[0]  = '{8'h00, 4, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h01, 4, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'h09, 4, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'h0A, 4, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h0B, 4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'h0C, 4, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'h02, 5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'h03, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'h05, 3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{8'h07, 2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{8'h80, 2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        foreach (tbl[k]) begin
            do_reset();
            cyc(1'b0, 1'b1, tbl[k].op);
            chk($sformatf("tbl%0d_ir_load0", k), 32'(ir_load), 32'd1);
            lat = 0; s_alu = 2'b00; s_src = 0; s_r2r = 0;
            s_rw = 0; s_mw = 0; s_jp = 0; s_il = 0;
            for (int c = 1; c < 10; c++) begin
                cyc(1'b0, 1'b1, tbl[k].op);
                if (c == 2) begin s_alu = alu_op; s_src = alu_src; end
                if (reg_write) begin s_rw = 1; s_r2r = reg_to_reg; end
                s_mw |= mem_write; s_jp |= jump; s_il |= illegal_op;
                if (ir_load && lat == 0) lat = c;
            end
            chk($sformatf("tbl%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
            chk($sformatf("tbl%0d_exec_alu_op", k), 32'(s_alu), 32'(tbl[k].ex_alu));
            chk($sformatf("tbl%0d_exec_alu_src", k), 32'(s_src), 32'(tbl[k].ex_src));
            chk($sformatf("tbl%0d_reg_write", k), 32'(s_rw), 32'(tbl[k].rw));
            chk($sformatf("tbl%0d_reg_to_reg", k), 32'(s_r2r), 32'(tbl[k].r2r));
            chk($sformatf("tbl%0d_mem_write", k), 32'(s_mw), 32'(tbl[k].mw));
            chk($sformatf("tbl%0d_jump", k), 32'(s_jp), 32'(tbl[k].jp));
            chk($sformatf("tbl%0d_illegal", k), 32'(s_il), 32'(tbl[k].il));
        end

        // Illegal opcode pulses once, then the next fetch begins.
        do_reset();
        cyc(1'b0, 1'b1, 8'h07);
        cyc(1'b0, 1'b1, 8'h00);
        chk("ill_pulse_c1", 32'({illegal_op, reg_write, mem_write}), 32'b100);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ill_fetch_c2", 32'({illegal_op, mem_read, i_or_d}), 32'b010);

        // Load with three wait cycles in MEM; opcode input changes after fetch.
        do_reset();
        cyc(1'b0, 1'b1, 8'h02);
        chk("ld_ir_load", 32'(ir_load), 32'd1);
        cnt_m = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc(1'b0, (c >= 6), 8'h0A);
            if (mem_read && i_or_d) cnt_m++;
            if (c == 7) chk("ld_wb", 32'({reg_write, reg_to_reg}), 32'b10);
        end
        chk("ld_mem_cycles", 32'(cnt_m), 32'd4);
        cyc(1'b0, 1'b1, 8'h09);
        chk("ld_refetch_c8", 32'(ir_load), 32'd1);

        // Fetch timeout -> sticky fault; reset clears it.
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            cyc(1'b0, 1'b0, 8'h09);
            chk($sformatf("to_wait_c%0d", c), 32'({busy, fault}), 32'b10);
        end
        for (int c = 16; c < 22; c++) begin
            cyc(1'b0, 1'(c % 2), 8'h09);
            chk($sformatf("to_fault_c%0d", c), 32'({busy, fault, mem_read, ir_load}), 32'b0100);
        end
        do_reset();
        chk("to_reset_clears", 32'({busy, fault}), 32'b10);
        for (int c = 0; c <= 14; c++) cyc(1'b0, 1'b0, 8'h09);
        cyc(1'b0, 1'b1, 8'h09);
        chk("to_ready_at_limit", 32'(ir_load), 32'd1);
        cyc(1'b0, 1'b0, 8'h09);
        chk("to_no_fault", 32'({busy, fault}), 32'b10);

        // Halt is terminal regardless of mem_ready.
        do_reset();
        cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b0, 1'b1, 8'h00);
        chk("halt_c1", 32'(halted), 32'd0);
        for (int c = 2; c < 22; c++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            chk($sformatf("halt_c%0d", c), 32'({halted, busy, mem_read, ir_load}), 32'b1000);
        end

        // Reset in the middle of a store's MEM wait.
        do_reset();
        cyc(1'b0, 1'b1, 8'h03);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("st_mem_write", 32'({mem_write, i_or_d}), 32'b11);
        cyc(1'b1, 1'b1, 8'h00);
        chk("st_rst_drop", 32'(mem_write), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("st_after_rst_fetch", 32'({mem_write, mem_read, i_or_d, busy}), 32'b0101);

        // Randomized run against the reference model.
        do_reset();
        m_reset();
        prob = 95;
        for (int n = 0; n < 6000; n++) begin
            logic       rdy;
            logic [7:0] op;
            if (n % 400 == 0) begin
                case ($urandom_range(0, 2))
                    0: prob = 10;
                    1: prob = 50;
                    default: prob = 95;
                endcase
            end
            rr  = ($urandom_range(0, 199) == 0) || (m_term && $urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 99) < prob);
            op  = pick_op();
            cyc(rr, rdy, op);
            e = rr ? reset_exp() : model_exp(m_phase(), m_op, rdy);
            chk($sformatf("rand_n%0d", n), 32'(w_out), 32'(e));
            if (rr) m_reset();
            else    m_step(rdy, op);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, sequential successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a memory-ready handshake.
- Latches the opcode, drives datapath controls per phase, and flags illegal opcodes and memory timeouts.
- Sits between the instruction/data memory ports and the datapath (PC, IR, register file, ALU).

Parameters:
- OPCODE_W, 8, opcode width. Opcodes are the 8-bit table values zero-extended.
- ALUOP_W, 2, width of alu_op. Values: 00 AND, 01 OR, 10 ADD/pass, 11 SUB.
- TIMEOUT, 15, max wait cycles for mem_ready in FETCH or MEM before FAULT. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  opcode field of the fetched instruction word. Sampled when ir_load=1.
- mem_ready  in  1  memory completes the current read or write this cycle.
- ir_load  out  1  load IR and latch opcode (FETCH with mem_ready).
- pc_write  out  1  update PC this cycle.
- jump  out  1  PC source = jump target (valid with pc_write).
- mem_read  out  1  memory read request (instruction in FETCH, data in MEM).
- i_or_d  out  1  0 = instruction address, 1 = data address.
- mem_write  out  1  data memory write request.
- alu_op  out  ALUOP_W  ALU operation.
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- reg_write  out  1  register-file write enable (WB only).
- reg_to_reg  out  1  WB source: 1 = ALU/move result, 0 = memory/ALU path as per opcode table.
- busy  out  1  high in every state except HALT and FAULT.
- halted  out  1  sticky; HALT opcode executed.
- illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode.
- fault  out  1  sticky; memory timeout.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FETCH, latched opcode=0, wait counter=0.
  - Every output 0 except busy=1.
  - rst overrides any in-flight memory transaction. The transaction is abandoned and mem_read/mem_write drop on the next cycle.
- FETCH:
  - mem_read=1, i_or_d=0.
  - If mem_ready: ir_load=1, pc_write=1 (PC+1), latch opcode, go to DECODE.
  - Else increment the wait counter.
- DECODE: one cycle; classify the latched opcode.
  - 0x00/0x01/0x09/0x0A/0x0B/0x0C: go to EXEC.
  - 0x02/0x03: go to EXEC (address calc).
  - 0x05: go to EXEC.
  - 0xFF: go to HALT.
  - Other: illegal_op=1, go to FETCH (treated as NOP).
- EXEC: one cycle. alu_op and alu_src follow the opcode table: mov imm 10/1, mov reg 10/0, add 10/0, sub 11/0, and 00/0, or 01/0, jmp 10/1, ld 10/0, st 00/0.
  - jmp: jump=1, pc_write=1, go to FETCH.
  - ld/st: go to MEM.
  - Otherwise: go to WB.
- MEM: i_or_d=1; mem_read=1 (ld) or mem_write=1 (st), held until mem_ready.
  - On mem_ready: ld goes to WB, st goes to FETCH.
- WB: one cycle. reg_write=1. reg_to_reg=1 for mov imm/mov reg, 0 otherwise. alu_op/alu_src hold their EXEC values. Go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH and MEM and on every mem_ready.
  - If it reaches TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready in the same cycle the counter reaches TIMEOUT wins: normal progress, no fault.
- HALT and FAULT:
  - Terminal; only rst exits.
  - All request/enable outputs 0; busy=0; halted or fault=1 respectively.
- Latency with mem_ready tied high:
  - ALU/mov: 4 cycles/instr.
  - ld: 5.
  - st: 4.
  - jmp: 3.
  - illegal: 2.
- Control outputs are Moore-decoded from state plus latched opcode, except ir_load/pc_write in FETCH and the MEM exit, which are gated by mem_ready.
- The latched opcode changes only on ir_load. The opcode input is don't-care otherwise.

Decomposition:
- Shared package `ctrl_pkg`:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT).
  - opcode constants (OP_MOVI=0x00, OP_MOVR=0x01, OP_LD=0x02, OP_ST=0x03, OP_JMP=0x05, OP_ADD=0x09, OP_SUB=0x0A, OP_AND=0x0B, OP_OR=0x0C, OP_HALT=0xFF).
  - ALU op constants.
- Sub-module `ctrl_opcode_decode`: combinational opcode to {class, alu_op, alu_src, reg_to_reg, legal}, instantiated once on the latched opcode.

Test Plan:
- rst, mem_ready=1, opcode 0x09 -> states FETCH, DECODE, EXEC, WB. ir_load at cycle 0, alu_op=10 at cycle 2, reg_write=1 at cycle 3, reg_to_reg=0, ir_load again at cycle 4.
- Opcode 0x02, mem_ready low for 3 MEM cycles then high -> mem_read=1 and i_or_d=1 for 4 cycles, then WB with reg_write=1 and reg_to_reg=0. Total 8 cycles.
- Opcode 0x05 -> jump=1 and pc_write=1 in EXEC (cycle 2), reg_write never set, FETCH at cycle 3.
- Opcode 0x07 -> illegal_op pulses exactly once in cycle 1, no reg_write/mem_write, FETCH at cycle 2.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> fault=1 and busy=0 after cycle 15, sticky. rst clears to FETCH with fault=0. A second run with mem_ready=1 exactly at the 15th wait cycle -> no fault.
- Opcode 0xFF -> halted=1 from cycle 2 and stays 1 for 20 cycles regardless of mem_ready. rst asserted mid-MEM of a store -> mem_write=0 the next cycle, state FETCH.
